// File: rtl/uart_rx_os_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_os_pkg
//   Shared definitions for the oversampling UART receive path: FSM state
//   encoding, oversample ratio, mid-bit sample slots and the bit-end slot,
//   plus the 3-sample majority helper used for bit decisions.
// ---------------------------------------------------------------------------
package uart_rx_os_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    // Oversample ticks per bit period.
    localparam int unsigned OS = 16;

    // Oversample slots: three mid-bit samples and the last slot of the bit.
    localparam logic [3:0] OS_SMP_A   = 4'd7;
    localparam logic [3:0] OS_SMP_B   = 4'd8;
    localparam logic [3:0] OS_SMP_C   = 4'd9;
    localparam logic [3:0] OS_BIT_END = 4'd15;

    // Two-of-three vote; tolerates one corrupted sample per bit.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//   Restartable oversample tick generator. Counts 0..DIV-1 with
//   DIV = CLK_HZ / (BAUD * OS) (truncated) and pulses tick for one clock
//   when the count is at DIV-1. restart forces the count back to zero so the
//   tick phase can be aligned to a detected start edge. Also usable to time
//   the transmit side.
//
//   Ports:
//     clk      in  1  system clock, rising edge
//     rst      in  1  synchronous active-high reset
//     restart  in  1  clear the divider count this clock
//     tick     out 1  one-clock pulse every DIV clocks
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600,
    parameter int unsigned OS     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned DIV = CLK_HZ / (BAUD * OS);
    localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] tick_cnt_q;
    logic [W-1:0] tick_cnt_d;

    assign tick = (tick_cnt_q == W'(DIV - 1));

    always_comb begin
        tick_cnt_d = tick_cnt_q + W'(1);
        if (restart || tick) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os
//   8N1 UART receiver with 16x oversampling and majority-vote bit decisions.
//   Self-timed from an internal oversample tick that is re-phased on every
//   start edge. rx_int is high from a validated start bit until mid stop bit;
//   its falling edge (coincident with rx_valid) marks rx_data valid.
//
//   Ports:
//     clk        in  1  system clock, rising edge
//     rst        in  1  synchronous active-high reset
//     rs232_rx   in  1  asynchronous serial line, idle high
//     rx_data    out 8  last received byte (LSB first on the line)
//     rx_int     out 1  frame-in-flight flag
//     rx_valid   out 1  one-clock pulse when rx_data updates
//     frame_err  out 1  one-clock pulse with rx_valid if stop bit was low
// ---------------------------------------------------------------------------
module uart_rx_os
    import uart_rx_os_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       rx_valid,
    output logic       frame_err
);

    // Two-stage synchroniser, reset to the idle level.
    logic sync1_q;
    logic sync2_q;
    logic rxs;

    rx_state_e  state_q,     state_d;
    logic [3:0] os_cnt_q,    os_cnt_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [1:0] smp_q,       smp_d;
    logic [7:0] shreg_q,     shreg_d;
    logic [7:0] rx_data_q,   rx_data_d;
    logic       rx_int_q,    rx_int_d;
    logic       rx_valid_q,  rx_valid_d;
    logic       frame_err_q, frame_err_d;

    logic tick;
    logic restart;
    logic bit_v;
    logic at_mid;
    logic at_end;

    assign rxs = sync2_q;

    // Divider and oversample count are re-phased on the IDLE->START edge.
    assign restart = (state_q == ST_IDLE) && !rxs;

    uart_baud_tick #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .OS     (OS)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // The third sample is taken live at slot 9, so the decision is available
    // in the same clock as the slot-9 tick.
    assign bit_v  = majority3(smp_q[0], smp_q[1], rxs);
    assign at_mid = tick && (os_cnt_q == OS_SMP_C);
    assign at_end = tick && (os_cnt_q == OS_BIT_END);

    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        smp_d       = smp_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_int_d    = rx_int_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (tick) begin
            os_cnt_d = os_cnt_q + 4'd1;
            if (os_cnt_q == OS_SMP_A) smp_d[0] = rxs;
            if (os_cnt_q == OS_SMP_B) smp_d[1] = rxs;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d  = ST_START;
                    os_cnt_d = '0;
                end
            end

            ST_START: begin
                if (at_mid) begin
                    if (!bit_v) begin
                        rx_int_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (at_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end

            ST_DATA: begin
                if (at_mid) begin
                    shreg_d = {bit_v, shreg_q[7:1]};
                end else if (at_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end

            ST_STOP: begin
                // Leaving at mid stop bit gives half a bit of resync margin.
                if (at_mid) begin
                    rx_data_d  = shreg_q;
                    rx_int_d   = 1'b0;
                    rx_valid_d = 1'b1;
                    if (bit_v) begin
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                // A held-low line (break) must not be taken as a new start.
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= ST_IDLE;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            smp_q       <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_int_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rs232_rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            smp_q       <= smp_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_int_q    <= rx_int_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_int    = rx_int_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule
